// File: rtl/multi_port_occupancy.sv
// Exact occupancy counter for queues that push/pop several entries per cycle.
// Registered count/free/status outputs; rejected updates latch sticky error flags.
module multi_port_occupancy #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_PUSH  = 2,
  parameter int unsigned MAX_POP   = 2,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned AE_MARGIN = 1,
  // Set to 0 where rejected updates are provoked on purpose (e.g. a directed test).
  parameter bit          EVENT_ASSERT_EN = 1'b1,
  localparam int unsigned CW  = $clog2(DEPTH + 1),
  localparam int unsigned PSW = $clog2(MAX_PUSH + 1),
  localparam int unsigned PPW = $clog2(MAX_POP + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PSW-1:0] push_cnt,
  input  logic [PPW-1:0] pop_cnt,
  input  logic           clr_err,
  output logic [CW-1:0]  count,
  output logic [CW-1:0]  free,
  output logic           empty,
  output logic           almost_empty,
  output logic           almost_full,
  output logic           full,
  output logic           overflow_err,
  output logic           underflow_err
);

  // One extra bit so count - pop + push never wraps before the range check.
  localparam int unsigned AW = CW + 1;

  localparam logic [AW-1:0]  DEPTH_W   = AW'(DEPTH);
  localparam logic [AW-1:0]  AF_TH_W   = AW'(DEPTH - AF_MARGIN);
  localparam logic [AW-1:0]  AE_TH_W   = AW'(AE_MARGIN);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
  localparam logic [PSW-1:0] MAX_PUSH_W = PSW'(MAX_PUSH);
  localparam logic [PPW-1:0] MAX_POP_W  = PPW'(MAX_POP);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_q, free_d;
  logic          empty_q, empty_d;
  logic          almost_empty_q, almost_empty_d;
  logic          almost_full_q, almost_full_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [AW-1:0] count_ext;
  logic [AW-1:0] push_ext;
  logic [AW-1:0] pop_ext;
  logic [AW-1:0] sum_ext;
  logic [AW-1:0] next_ext;
  logic          underflow_ev;
  logic          overflow_ev;

  always_comb begin
    count_ext = AW'(count_q);
    push_ext  = AW'(push_cnt);
    pop_ext   = AW'(pop_cnt);
    sum_ext   = count_ext - pop_ext + push_ext;

    // Pops are judged against start-of-cycle occupancy; same-cycle pushes cannot cover them.
    underflow_ev = (pop_ext > count_ext);
    overflow_ev  = !underflow_ev && (sum_ext > DEPTH_W);

    next_ext = (underflow_ev || overflow_ev) ? count_ext : sum_ext;
  end

  always_comb begin
    count_d        = next_ext[CW-1:0];
    free_d         = DEPTH_C - next_ext[CW-1:0];
    empty_d        = (next_ext == '0);
    almost_empty_d = (next_ext <= AE_TH_W);
    almost_full_d  = (next_ext >= AF_TH_W);
    full_d         = (next_ext == DEPTH_W);
    // A new error in the clearing cycle wins over clr_err.
    overflow_d     = (overflow_q  && !clr_err) || overflow_ev;
    underflow_d    = (underflow_q && !clr_err) || underflow_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      free_q         <= DEPTH_C;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      full_q         <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      count_q        <= count_d;
      free_q         <= free_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      full_q         <= full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign count         = count_q;
  assign free          = free_q;
  assign empty         = empty_q;
  assign almost_empty  = almost_empty_q;
  assign almost_full   = almost_full_q;
  assign full          = full_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (push_cnt <= MAX_PUSH_W)
        else $error("multi_port_occupancy: push_cnt %0d exceeds MAX_PUSH", push_cnt);
      assert (pop_cnt <= MAX_POP_W)
        else $error("multi_port_occupancy: pop_cnt %0d exceeds MAX_POP", pop_cnt);
      if (EVENT_ASSERT_EN) begin
        assert (!underflow_ev)
          else $error("multi_port_occupancy: underflow, pop %0d with count %0d", pop_cnt, count_q);
        assert (!overflow_ev)
          else $error("multi_port_occupancy: overflow, count %0d pop %0d push %0d",
                      count_q, pop_cnt, push_cnt);
      end
    end
  end

endmodule

// File: tb/tb_multi_port_occupancy.sv
// Directed + random stimulus for multi_port_occupancy; expected state is queued
// when a step is driven and compared once the DUT has registered it.
module tb_multi_port_occupancy;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] push_cnt;
  logic [1:0] pop_cnt;
  logic       clr_err;
  logic [3:0] count;
  logic [3:0] free;
  logic       empty, almost_empty, almost_full, full;
  logic       overflow_err, underflow_err;

  typedef struct {
    string tag;
    int    cnt;
    int    fre;
    bit    emp;
    bit    ae;
    bit    af;
    bit    ful;
    bit    ovf;
    bit    unf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state, driven from the behavioural rules.
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always #5 clk = ~clk;

  multi_port_occupancy #(
    .DEPTH(8), .MAX_PUSH(2), .MAX_POP(2), .AF_MARGIN(1), .AE_MARGIN(1),
    .EVENT_ASSERT_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .push_cnt(push_cnt), .pop_cnt(pop_cnt), .clr_err(clr_err),
    .count(count), .free(free), .empty(empty), .almost_empty(almost_empty),
    .almost_full(almost_full), .full(full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic step(input string tag, input int p, input int q, input bit clr, input bit r);
    exp_t e;
    bit   uf, of;
    push_cnt = 2'(p);
    pop_cnt  = 2'(q);
    clr_err  = clr;
    rst      = r;
    if (r) begin
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      uf = (q > m_cnt);
      of = !uf && (m_cnt - q + p > DEPTH);
      if (!uf && !of) m_cnt = m_cnt + p - q;
      m_ovf = (m_ovf && !clr) || of;
      m_unf = (m_unf && !clr) || uf;
    end
    e.tag = tag;
    e.cnt = m_cnt;
    e.fre = DEPTH - m_cnt;
    e.emp = (m_cnt == 0);
    e.ae  = (m_cnt <= 1);
    e.af  = (m_cnt >= DEPTH - 1);
    e.ful = (m_cnt == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".count"},         int'(count),         e.cnt);
    chk({e.tag, ".free"},          int'(free),          e.fre);
    chk({e.tag, ".empty"},         int'(empty),         int'(e.emp));
    chk({e.tag, ".almost_empty"},  int'(almost_empty),  int'(e.ae));
    chk({e.tag, ".almost_full"},   int'(almost_full),   int'(e.af));
    chk({e.tag, ".full"},          int'(full),          int'(e.ful));
    chk({e.tag, ".overflow_err"},  int'(overflow_err),  int'(e.ovf));
    chk({e.tag, ".underflow_err"}, int'(underflow_err), int'(e.unf));
    $display("step %-10s push=%0d pop=%0d clr=%0d rst=%0d -> count=%0d free=%0d e=%0d ae=%0d af=%0d f=%0d ovf=%0d unf=%0d",
             tag, p, q, clr, r, count, free, empty, almost_empty, almost_full, full,
             overflow_err, underflow_err);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; push_cnt = '0; pop_cnt = '0; clr_err = 1'b0;
    @(posedge clk);
    #1;

    step("reset", 0, 0, 0, 1);
    chk("reset.free_const", int'(free), 8);

    for (int i = 0; i < 4; i++) step("fill", 2, 0, 0, 0);
    chk("fill.count_8", int'(count), 8);
    chk("fill.full_8", int'(full), 1);

    step("pop1", 0, 1, 0, 0);
    step("ovf", 2, 0, 0, 0);
    chk("ovf.count_held", int'(count), 7);
    chk("ovf.flag", int'(overflow_err), 1);
    step("ovf_legal", 2, 1, 0, 0);
    chk("ovf_legal.count", int'(count), 8);
    step("clr_ovf", 0, 0, 1, 0);
    chk("clr_ovf.flag", int'(overflow_err), 0);

    for (int i = 0; i < 3; i++) step("drain", 0, 2, 0, 0);
    step("drain1", 0, 1, 0, 0);
    step("unf", 2, 2, 0, 0);
    chk("unf.count_held", int'(count), 1);
    chk("unf.flag", int'(underflow_err), 1);
    chk("unf.no_ovf", int'(overflow_err), 0);
    step("clr_unf", 0, 0, 1, 0);
    chk("clr_unf.flag", int'(underflow_err), 0);

    step("to3", 2, 0, 0, 0);
    step("to4", 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("simul", 2, 2, 0, 0);
    chk("simul.count_4", int'(count), 4);
    step("to2", 0, 2, 0, 0);
    step("to1", 0, 1, 0, 0);
    step("clr_vs_unf", 0, 2, 1, 0);
    chk("clr_vs_unf.flag", int'(underflow_err), 1);

    for (int i = 0; i < 60; i++)
      step("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           ($urandom_range(0, 7) == 0), 1'b0);

    step("rst2", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("refill", 2, 0, 0, 0);
    chk("refill.count_6", int'(count), 6);
    step("rst_mid", 2, 0, 1, 1);
    chk("rst_mid.count_0", int'(count), 0);
    chk("rst_mid.empty", int'(empty), 1);

    rst = 1'b0; push_cnt = '0; pop_cnt = '0; clr_err = 1'b0;
    chk("scoreboard.drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
